// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the sequencer encoding, port ids and the latched transaction payload.
package dmem_pkg;

   localparam int unsigned DEF_DEPTH = 32;
   localparam int unsigned DEF_AW    = 5;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned NPORTS    = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_DMA  = 1'b1;

   // Attributes of the granted request, held from grant to response.
   typedef struct packed {
      logic id;
      logic we;
      logic err;
   } txn_t;

   function automatic logic [NPORTS-1:0] port_onehot(input logic id);
      return (id == PORT_CORE) ? 2'b01 : 2'b10;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; purely combinational.
// With both requests present the port named by i_rr_ptr wins.
module rr_arb2
   import dmem_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_rr_ptr,
   output logic       o_winner_c,
   output logic       o_valid_c
);

   always_comb begin
      o_valid_c  = |i_req;
      o_winner_c = PORT_CORE;
      unique case (i_req)
         2'b01:   o_winner_c = PORT_CORE;
         2'b10:   o_winner_c = PORT_DMA;
         2'b11:   o_winner_c = i_rr_ptr;
         default: o_winner_c = PORT_CORE;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (port 0) and the DMA loader (port 1).
// IDLE arbitrates and latches, ACCESS drives the memory, RESP returns rvalid/err/rdata.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned AW    = DEF_AW
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [1:0]  we,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic [1:0]  gnt,
   output logic [1:0]  rvalid,
   output logic [1:0]  err,
   output logic [31:0] rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wr_en,
   input  logic [31:0] mem_rdata
);

   state_t            r_state, w_state_nxt;
   logic              r_rr_ptr, w_rr_ptr_nxt;
   txn_t              r_txn, w_txn_nxt;
   logic [1:0]        r_gnt, w_gnt_nxt;
   logic [1:0]        r_rvalid, w_rvalid_nxt;
   logic [1:0]        r_err, w_err_nxt;
   logic [XLEN-1:0]   r_rdata, w_rdata_nxt;
   logic [XLEN-1:0]   r_mem_addr, w_mem_addr_nxt;
   logic [XLEN-1:0]   r_mem_wdata, w_mem_wdata_nxt;
   logic              r_mem_wr_en, w_mem_wr_en_nxt;

   logic              w_win, w_arb_valid;
   logic [XLEN-1:0]   w_sel_addr, w_sel_wdata;
   logic              w_sel_we, w_sel_err;

   rr_arb2 u_rr_arb2 (
      .i_req      (req),
      .i_rr_ptr   (r_rr_ptr),
      .o_winner_c (w_win),
      .o_valid_c  (w_arb_valid)
   );

   // Winner's request fields and its misaligned / out-of-range classification.
   always_comb begin
      w_sel_addr  = (w_win == PORT_DMA) ? addr1  : addr0;
      w_sel_wdata = (w_win == PORT_DMA) ? wdata1 : wdata0;
      w_sel_we    = we[w_win];
      w_sel_err   = (w_sel_addr[1:0] != 2'b00)
                 || (w_sel_addr[XLEN-1:AW+2] != '0)
                 || (w_sel_addr[XLEN-1:2] >= (XLEN-2)'(DEPTH));
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_txn_nxt       = r_txn;
      w_gnt_nxt       = '0;
      w_rvalid_nxt    = '0;
      w_err_nxt       = '0;
      w_rdata_nxt     = r_rdata;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_mem_wr_en_nxt = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (w_arb_valid) begin
               w_state_nxt     = ACCESS;
               w_txn_nxt       = '{id: w_win, we: w_sel_we, err: w_sel_err};
               w_gnt_nxt       = port_onehot(w_win);
               w_mem_addr_nxt  = XLEN'(w_sel_addr[AW+1:2]);
               w_mem_wdata_nxt = w_sel_wdata;
               w_mem_wr_en_nxt = w_sel_we & ~w_sel_err;
            end
         end
         ACCESS: begin
            w_state_nxt  = RESP;
            w_rdata_nxt  = (r_txn.we || r_txn.err) ? '0 : mem_rdata;
            w_rvalid_nxt = port_onehot(r_txn.id);
            w_err_nxt    = r_txn.err ? port_onehot(r_txn.id) : 2'b00;
         end
         RESP: begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = ~r_txn.id;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_rr_ptr    <= PORT_CORE;
         r_txn       <= '0;
         r_gnt       <= '0;
         r_rvalid    <= '0;
         r_err       <= '0;
         r_rdata     <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wr_en <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_txn       <= w_txn_nxt;
         r_gnt       <= w_gnt_nxt;
         r_rvalid    <= w_rvalid_nxt;
         r_err       <= w_err_nxt;
         r_rdata     <= w_rdata_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_mem_wr_en <= w_mem_wr_en_nxt;
      end
   end

   assign gnt       = r_gnt;
   assign rvalid    = r_rvalid;
   assign err       = r_err;
   assign rdata     = r_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   // A reset landing in ACCESS must kill the in-flight store before the memory edge.
   assign mem_wr_en = r_mem_wr_en & ~reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: data memory model plus a word-array reference.
// Expected results come from the address/error rules applied to the reference array.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic [1:0]  req, we;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [1:0]  gnt, rvalid, err;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_wr_en;

   logic        mem_init;
   logic [31:0] mem_model [32];
   logic [31:0] init_val  [32];
   logic [31:0] ref_mem   [32];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          wr_cnt = 0;
   logic [31:0] last_wr_addr, last_wr_data;

   dmem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .we        (we),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .err       (err),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wr_en (mem_wr_en),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: combinational read, write on the rising edge.
   assign mem_rdata = (mem_addr < 32'd32) ? mem_model[mem_addr[4:0]] : 32'hBAD0_BAD0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_init) begin
         for (int i = 0; i < 32; i++) mem_model[i] <= init_val[i];
      end else if (mem_wr_en) begin
         mem_model[mem_addr[4:0]] <= mem_wdata;
         wr_cnt       <= wr_cnt + 1;
         last_wr_addr <= mem_addr;
         last_wr_data <= mem_wdata;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic addr_bad(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'd128);
   endfunction

   function automatic logic [31:0] rand_word_addr();
      return 32'(($urandom % 32) * 4);
   endfunction

   function automatic logic [1:0] onehot(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

   // Issue one request from a negedge and follow it until its rvalid (bounded).
   task automatic run_txn(input logic p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int gnt_lat, output int rv_lat,
                          output logic [1:0] rv, output logic [1:0] er,
                          output logic [31:0] rd, output int rv_cyc);
      gnt_lat = -1; rv_lat = -1; rv = 2'b00; er = 2'b00; rd = 32'h0; rv_cyc = -1;
      req[p] = 1'b1;
      we[p]  = w;
      if (p) begin addr1 = a; wdata1 = d; end
      else   begin addr0 = a; wdata0 = d; end
      for (int n = 1; n <= 10 && rv_lat < 0; n++) begin
         @(negedge clk);
         if (gnt[p] && gnt_lat < 0) begin
            gnt_lat = n;
            req[p]  = 1'b0;
         end
         if (rvalid != 2'b00) begin
            rv_lat = n; rv = rvalid; er = err; rd = rdata; rv_cyc = cyc;
         end
      end
      req[p] = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 2'b00;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_init = 1'b1;
      req = 2'b00; we = 2'b00;
      addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
      for (int i = 0; i < 32; i++) begin
         init_val[i] = $urandom;
         ref_mem[i]  = init_val[i];
      end
      @(negedge clk);
      @(negedge clk);
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
      checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err); end
      checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", mem_wr_en); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
      mem_init = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_store_load();
      int gl, rl, rc, w0;
      logic [1:0] rv, er;
      logic [31:0] rd;
      w0 = wr_cnt;
      run_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, gl, rl, rv, er, rd, rc);
      ref_mem[4] = 32'hDEADBEEF;
      checks++; if (gl !== 1) begin errors++; $display("FAIL st_gnt_lat: got %0d expected 1", gl); end
      checks++; if (rl !== 2) begin errors++; $display("FAIL st_rv_lat: got %0d expected 2", rl); end
      checks++; if (rv !== 2'b01 || er !== 2'b00) begin errors++; $display("FAIL st_rv_err: got %b/%b expected 01/00", rv, er); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL st_rdata: got %h expected 0", rd); end
      checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL st_wr_count: got %0d expected 1", wr_cnt - w0); end
      checks++; if (last_wr_addr !== 32'd4 || last_wr_data !== 32'hDEADBEEF) begin
         errors++; $display("FAIL st_wr_target: got %h/%h expected 4/deadbeef", last_wr_addr, last_wr_data);
      end
      @(negedge clk);
      run_txn(1'b0, 1'b0, 32'h10, $urandom, gl, rl, rv, er, rd, rc);
      checks++; if (rl !== 2 || rv !== 2'b01) begin errors++; $display("FAIL ld_rv: got lat %0d rv %b expected 2/01", rl, rv); end
      checks++; if (rd !== ref_mem[4]) begin errors++; $display("FAIL ld_rdata: got %h expected %h", rd, ref_mem[4]); end
      @(negedge clk);
   endtask

   task automatic test_fairness();
      logic [1:0] exp_g, exp_rv;
      logic [31:0] exp_rd;
      do_reset();
      addr0 = rand_word_addr(); addr1 = rand_word_addr();
      we = 2'b00; req = 2'b11;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         exp_g  = (k % 3 == 1) ? onehot(1'(((k - 1) / 3) % 2)) : 2'b00;
         exp_rv = (k % 3 == 2) ? onehot(1'(((k - 2) / 3) % 2)) : 2'b00;
         checks++; if (gnt !== exp_g) begin errors++; $display("FAIL fair_gnt k=%0d: got %b expected %b", k, gnt, exp_g); end
         checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL fair_rvalid k=%0d: got %b expected %b", k, rvalid, exp_rv); end
         if (exp_rv != 2'b00) begin
            exp_rd = exp_rv[1] ? ref_mem[addr1[6:2]] : ref_mem[addr0[6:2]];
            checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL fair_rdata k=%0d: got %h expected %h", k, rdata, exp_rd); end
         end
      end
      req = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_errors();
      int gl, rl, rc, w0, w1, bad;
      logic [1:0] rv, er, exp_er;
      logic [31:0] rd, a, d, exp_rd;
      logic p, w, e;
      w0 = wr_cnt;
      run_txn(1'b1, 1'b0, 32'h06, $urandom, gl, rl, rv, er, rd, rc);
      checks++; if (rv !== 2'b10 || er !== 2'b10) begin errors++; $display("FAIL err_misalign: got rv %b err %b expected 10/10", rv, er); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_misalign_rdata: got %h expected 0", rd); end
      @(negedge clk);
      run_txn(1'b0, 1'b1, 32'h80, 32'h1234, gl, rl, rv, er, rd, rc);
      checks++; if (rv !== 2'b01 || er !== 2'b01) begin errors++; $display("FAIL err_range: got rv %b err %b expected 01/01", rv, er); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_range_rdata: got %h expected 0", rd); end
      checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL err_no_write: got %0d writes expected 0", wr_cnt - w0); end
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         p = 1'($urandom % 2);
         w = 1'($urandom % 2);
         d = $urandom;
         case ($urandom % 3)
            0:       a = rand_word_addr();
            1:       a = rand_word_addr() | 32'(1 + $urandom % 3);
            default: a = $urandom | 32'h0000_0080;
         endcase
         e      = addr_bad(a);
         exp_er = e ? onehot(p) : 2'b00;
         exp_rd = (w || e) ? 32'h0 : ref_mem[a[6:2]];
         w1     = wr_cnt;
         run_txn(p, w, a, d, gl, rl, rv, er, rd, rc);
         if (w && !e) ref_mem[a[6:2]] = d;
         checks++; if (rv !== onehot(p) || er !== exp_er) begin
            errors++; $display("FAIL err_rand%0d a=%h: got rv %b err %b expected %b/%b", i, a, rv, er, onehot(p), exp_er);
         end
         checks++; if (rd !== exp_rd) begin errors++; $display("FAIL err_rand%0d_rdata: got %h expected %h", i, rd, exp_rd); end
         checks++; if (wr_cnt - w1 !== int'(w && !e)) begin
            errors++; $display("FAIL err_rand%0d_writes: got %0d expected %0d", i, wr_cnt - w1, int'(w && !e));
         end
         @(negedge clk);
      end
      bad = 0;
      for (int i = 0; i < 32; i++) if (mem_model[i] !== ref_mem[i]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL err_mem_contents: got %0d differing words expected 0", bad); end
   endtask

   task automatic test_reset_mid();
      int gl, rl, rc, w0, seen_rv;
      logic [1:0] rv, er;
      logic [31:0] rd;
      run_txn(1'b0, 1'b0, rand_word_addr(), 32'h0, gl, rl, rv, er, rd, rc);
      @(negedge clk);
      w0 = wr_cnt;
      we[0] = 1'b1; addr0 = 32'h08; wdata0 = ~ref_mem[2]; req = 2'b01;
      @(negedge clk);
      checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rmid_gnt: got %b expected 01", gnt); end
      checks++; if (mem_wr_en !== 1'b1 || mem_addr !== 32'd2) begin
         errors++; $display("FAIL rmid_inflight: got wr_en %b addr %h expected 1/2", mem_wr_en, mem_addr);
      end
      req = 2'b00;
      reset = 1'b1;
      #1;
      checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rmid_wr_en: got %b expected 0", mem_wr_en); end
      @(negedge clk);
      reset = 1'b0;
      seen_rv = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (rvalid != 2'b00) seen_rv++;
      end
      checks++; if (seen_rv !== 0) begin errors++; $display("FAIL rmid_no_rvalid: got %0d pulses expected 0", seen_rv); end
      checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL rmid_no_write: got %0d writes expected 0", wr_cnt - w0); end
      addr0 = rand_word_addr(); addr1 = rand_word_addr(); we = 2'b00; req = 2'b11;
      @(negedge clk);
      checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rmid_ptr_reset: got %b expected 01", gnt); end
      req = 2'b00;
      @(negedge clk);
      @(negedge clk);
      run_txn(1'b1, 1'b0, 32'h08, 32'h0, gl, rl, rv, er, rd, rc);
      checks++; if (rv !== 2'b10 || rd !== ref_mem[2]) begin
         errors++; $display("FAIL rmid_reload: got rv %b rdata %h expected 10/%h", rv, rd, ref_mem[2]);
      end
      @(negedge clk);
   endtask

   task automatic test_lone();
      int gl, rl, rc;
      logic [1:0] rv, er;
      logic [31:0] rd, a;
      for (int j = 0; j < 2; j++) begin
         run_txn(1'(j), 1'b0, rand_word_addr(), 32'h0, gl, rl, rv, er, rd, rc);
         @(negedge clk);
         a = rand_word_addr();
         run_txn(1'(j), 1'b0, a, 32'h0, gl, rl, rv, er, rd, rc);
         checks++; if (gl !== 1 || rl !== 2) begin
            errors++; $display("FAIL lone_p%0d_latency: got gnt %0d rv %0d expected 1/2", j, gl, rl);
         end
         checks++; if (rv !== onehot(1'(j)) || rd !== ref_mem[a[6:2]]) begin
            errors++; $display("FAIL lone_p%0d_data: got rv %b rdata %h expected %b/%h", j, rv, rd, onehot(1'(j)), ref_mem[a[6:2]]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int gl, rl, rc, prev;
      logic [1:0] rv, er;
      logic [31:0] rd;
      prev = -1;
      for (int i = 0; i < 64; i++) begin
         if (i < 32) begin
            run_txn(1'b1, 1'b1, 32'(i * 4), 32'(i * 3), gl, rl, rv, er, rd, rc);
            ref_mem[i] = 32'(i * 3);
         end else begin
            run_txn(1'b1, 1'b0, 32'((i - 32) * 4), 32'h0, gl, rl, rv, er, rd, rc);
            checks++; if (rd !== ref_mem[i - 32]) begin
               errors++; $display("FAIL sweep_read%0d: got %h expected %h", i - 32, rd, ref_mem[i - 32]);
            end
         end
         checks++; if (rv !== 2'b10 || er !== 2'b00) begin errors++; $display("FAIL sweep%0d_rv: got %b/%b expected 10/00", i, rv, er); end
         if (prev >= 0) begin
            checks++; if (rc - prev !== 3) begin errors++; $display("FAIL sweep%0d_spacing: got %0d expected 3", i, rc - prev); end
         end
         prev = rc;
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_fairness();
      test_errors();
      test_reset_mid();
      test_lone();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
